burst_bus_master: RTL and testbench

- Converts burst read/write commands into single-beat transactions on the 256x16 memory bus: write, 8-bit address, 16-bit data_in, 16-bit data_out.
- Sits directly upstream of the memory slave and drives its input side.
- Returns read data as a valid/last stream.
- Lets higher-level stimulus and DMA-style logic issue multi-word accesses without cycle-by-cycle bus control.

---
 rtl/burst_bus_pkg.sv | 12 +
 rtl/rd_lat_pipe.sv | 33 +++
 rtl/burst_bus_master.sv | 124 ++++++++++++
 tb/tb_burst_bus_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/burst_bus_pkg.sv
// Shared types and widths for the burst bus master and its read-latency pipe.
package burst_bus_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } rd_tag_t;
endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep shift register of read tags, aligned so the tail lines up with slave data_out.
// Empty flag reports that no issued read is still waiting for its data.
module rd_lat_pipe
   import burst_bus_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag,
   output logic    o_empty
);
   rd_tag_t r_stage [RD_LAT];
   logic    w_any;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   always_comb begin
      w_any = 1'b0;
      for (int i = 0; i < RD_LAT; i++) w_any = w_any | r_stage[i].valid;
   end

   assign o_tag   = r_stage[RD_LAT-1];
   assign o_empty = !w_any;
endmodule

// File: rtl/burst_bus_master.sv
// Splits burst commands into single-beat accesses on the 256x16 bus; read data returns RD_LAT+1
// cycles after each address. Commands stall (cmd_ready=0) while a burst is active; rd stream has no backpressure.
module burst_bus_master
   import burst_bus_pkg::*;
#(
   parameter int RD_LAT    = 1,
   parameter int MAX_LEN_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDR_W-1:0]    cmd_addr,
   input  logic [MAX_LEN_W-1:0] cmd_len,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [DATA_W-1:0]    wr_data,
   output logic                 rd_valid,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_last,
   output logic                 busy,
   output logic                 write,
   output logic [ADDR_W-1:0]    address,
   output logic [DATA_W-1:0]    data_in,
   input  logic [DATA_W-1:0]    data_out
);
   localparam logic [MAX_LEN_W-1:0] CNT_ONE = {{(MAX_LEN_W-1){1'b0}}, 1'b1};

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_W-1:0]     r_ptr;
   logic [MAX_LEN_W-1:0]  r_cnt;
   logic                  r_write;
   logic [ADDR_W-1:0]     r_address;
   logic [DATA_W-1:0]     r_data_in;
   rd_tag_t               r_tag;
   logic                  r_rd_valid;
   logic [DATA_W-1:0]     r_rd_data;
   logic                  r_rd_last;
   rd_tag_t               w_tail;
   logic                  w_pipe_empty;
   logic                  w_cmd_acc;
   logic                  w_wr_acc;

   assign cmd_ready = (r_state == IDLE) && rst_n;
   assign wr_ready  = (r_state == WR);
   assign busy      = (r_state != IDLE);
   assign w_cmd_acc = cmd_valid && cmd_ready;
   assign w_wr_acc  = wr_valid && wr_ready;

   assign write    = r_write;
   assign address  = r_address;
   assign data_in  = r_data_in;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign rd_last  = r_rd_last;

   // r_tag is registered alongside r_address, so the pipe tail meets data_out RD_LAT cycles later.
   rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_tag   (r_tag),
      .o_tag   (w_tail),
      .o_empty (w_pipe_empty)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_cmd_acc) w_next = cmd_write ? WR : RD_ISSUE;
         WR:       if (w_wr_acc && (r_cnt == '0)) w_next = IDLE;
         RD_ISSUE: if (r_cnt == '0) w_next = RD_DRAIN;
         RD_DRAIN: if (!r_tag.valid && w_pipe_empty) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_write    <= 1'b0;
         r_address  <= '0;
         r_data_in  <= '0;
         r_tag      <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_last  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_write <= 1'b0;
         r_tag   <= '0;
         case (r_state)
            IDLE: begin
               if (w_cmd_acc) begin
                  r_ptr <= cmd_addr;
                  r_cnt <= cmd_len;
               end
            end
            WR: begin
               if (w_wr_acc) begin
                  r_write   <= 1'b1;
                  r_address <= r_ptr;
                  r_data_in <= wr_data;
                  r_ptr     <= r_ptr + 8'd1;
                  r_cnt     <= r_cnt - CNT_ONE;
               end
            end
            RD_ISSUE: begin
               r_address <= r_ptr;
               r_tag     <= '{valid: 1'b1, last: (r_cnt == '0)};
               r_ptr     <= r_ptr + 8'd1;
               r_cnt     <= r_cnt - CNT_ONE;
            end
            default: ;
         endcase
         r_rd_valid <= w_tail.valid;
         r_rd_last  <= w_tail.valid && w_tail.last;
         if (w_tail.valid) r_rd_data <= data_out;
      end
   end
endmodule

// File: tb/tb_burst_bus_master.sv
// Directed bench: two masters (RD_LAT=1 and RD_LAT=3) sharing one behavioural 256x16 memory.
module tb_burst_bus_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid, rd_last, busy, write;
   logic [15:0] rd_data, data_in, data_out;
   logic [7:0]  address;

   logic        cmd_valid2, cmd_ready2, cmd_write2;
   logic [7:0]  cmd_addr2;
   logic [3:0]  cmd_len2;
   logic        wr_valid2, wr_ready2;
   logic [15:0] wr_data2;
   logic        rd_valid2, rd_last2, busy2, write2;
   logic [15:0] rd_data2, data_in2, data_out2;
   logic [7:0]  address2;

   logic [15:0] mem [256];
   logic [7:0]  a_d;
   logic [7:0]  b_d [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   burst_bus_master #(.RD_LAT(1), .MAX_LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
      .write(write), .address(address), .data_in(data_in), .data_out(data_out)
   );

   burst_bus_master #(.RD_LAT(3), .MAX_LEN_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_write(cmd_write2), .cmd_addr(cmd_addr2), .cmd_len(cmd_len2),
      .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
      .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_last(rd_last2), .busy(busy2),
      .write(write2), .address(address2), .data_in(data_in2), .data_out(data_out2)
   );

   // Slave: registered read address, data valid RD_LAT cycles after the address cycle.
   always @(posedge clk) begin
      if (write) mem[address] <= data_in;
      a_d    <= address;
      b_d[0] <= address2;
      b_d[1] <= b_d[0];
      b_d[2] <= b_d[1];
   end
   assign data_out  = mem[a_d];
   assign data_out2 = mem[b_d[2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] ea;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      wr_valid = 0; wr_data = 0;
      cmd_valid2 = 0; cmd_write2 = 0; cmd_addr2 = 0; cmd_len2 = 0;
      wr_valid2 = 0; wr_data2 = 0;

      // Reset state
      step(); step();
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_wr_ready",  32'(wr_ready), 0);
      check("rst_busy",      32'(busy), 0);
      check("rst_write",     32'(write), 0);
      check("rst_address",   32'(address), 0);
      check("rst_data_in",   32'(data_in), 0);
      check("rst_rd_valid",  32'(rd_valid), 0);
      check("rst_rd_data",   32'(rd_data), 0);
      check("rst_rd_last",   32'(rd_last), 0);
      rst_n = 1'b1;
      #1;
      check("rst_release_ready", 32'(cmd_ready), 1);

      // Write burst 0x10 len 3; stray wr beat in IDLE must be ignored
      wr_valid = 1'b1; wr_data = 16'hDEAD;
      check("stray_wr_ready", 32'(wr_ready), 0);
      issue(1'b1, 8'h10, 4'd3);
      check("wr_busy",       32'(busy), 1);
      check("wr_cmd_ready",  32'(cmd_ready), 0);
      check("wr_wr_ready",   32'(wr_ready), 1);
      check("wr_write_idle", 32'(write), 0);
      for (int i = 0; i < 4; i++) begin
         wr_data = 16'hA000 + 16'(i);
         step();
         check("wr_write", 32'(write), 1);
         check("wr_addr",  32'(address), 32'(8'h10 + 8'(i)));
         check("wr_data",  32'(data_in), 32'(16'hA000 + 16'(i)));
      end
      wr_valid = 1'b0;
      check("wr_done_ready", 32'(cmd_ready), 1);
      step();
      check("wr_write_deassert", 32'(write), 0);

      // Wrap write 0xFE len 2 -> FE, FF, 00
      issue(1'b1, 8'hFE, 4'd2);
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 16'hB000 + 16'(i);
         step();
         ea = 8'hFE + 8'(i);
         check("wrap_write", 32'(write), 1);
         check("wrap_addr",  32'(address), 32'(ea));
      end
      wr_valid = 1'b0;
      step();

      // Stalled 2-beat write at 0x20 with wr_valid pattern 1,0,0,1
      issue(1'b1, 8'h20, 4'd1);
      wr_valid = 1'b1; wr_data = 16'hC000;
      step();
      check("stall_w0",    32'(write), 1);
      check("stall_a0",    32'(address), 32'h20);
      wr_valid = 1'b0; wr_data = 16'h5555;
      step();
      check("stall_gap1",  32'(write), 0);
      check("stall_hold_a", 32'(address), 32'h20);
      check("stall_hold_d", 32'(data_in), 32'hC000);
      step();
      check("stall_gap2",  32'(write), 0);
      wr_valid = 1'b1; wr_data = 16'hC001;
      step();
      check("stall_w1",    32'(write), 1);
      check("stall_a1",    32'(address), 32'h21);
      check("stall_d1",    32'(data_in), 32'hC001);
      wr_valid = 1'b0;
      check("stall_ready", 32'(cmd_ready), 1);
      step();
      check("stall_mem20", 32'(mem[8'h20]), 32'hC000);
      check("stall_mem21", 32'(mem[8'h21]), 32'hC001);

      // Read burst 0x10 len 3
      issue(1'b0, 8'h10, 4'd3);
      step();
      check("rd_addr0",   32'(address), 32'h10);
      check("rd_write0",  32'(write), 0);
      check("rd_early0",  32'(rd_valid), 0);
      step();
      check("rd_addr1",   32'(address), 32'h11);
      check("rd_early1",  32'(rd_valid), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rd_valid", 32'(rd_valid), 1);
         check("rd_data",  32'(rd_data), 32'(16'hA000 + 16'(i)));
         check("rd_last",  32'(rd_last), (i == 3) ? 1 : 0);
      end
      step();
      check("rd_end_valid", 32'(rd_valid), 0);
      check("rd_end_busy",  32'(busy), 0);

      // Wrapping read 0xFE len 2
      issue(1'b0, 8'hFE, 4'd2);
      step(); step();
      for (int i = 0; i < 3; i++) begin
         step();
         check("rdw_valid", 32'(rd_valid), 1);
         check("rdw_data",  32'(rd_data), 32'(16'hB000 + 16'(i)));
      end
      step();
      check("rdw_end", 32'(rd_valid), 0);

      // Reset after two of eight read addresses
      issue(1'b0, 8'h10, 4'd7);
      step();
      step();
      check("mid_busy", 32'(busy), 1);
      rst_n = 1'b0;
      step();
      check("mid_write",    32'(write), 0);
      check("mid_rd_valid", 32'(rd_valid), 0);
      check("mid_busy_rst", 32'(busy), 0);
      check("mid_ready_rst", 32'(cmd_ready), 0);
      rst_n = 1'b1;
      #1;
      check("mid_ready_rel", 32'(cmd_ready), 1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("mid_no_stale", 32'(rd_valid), 0);
      end

      // RD_LAT=3 instance, single-beat read at 0x10
      cmd_valid2 = 1'b1; cmd_addr2 = 8'h10; cmd_len2 = 4'd0;
      step();
      cmd_valid2 = 1'b0;
      step();
      check("l3_addr", 32'(address2), 32'h10);
      for (int k = 0; k < 3; k++) begin
         step();
         check("l3_early", 32'(rd_valid2), 0);
      end
      step();
      check("l3_valid", 32'(rd_valid2), 1);
      check("l3_last",  32'(rd_last2), 1);
      check("l3_data",  32'(rd_data2), 32'hA000);
      step();
      check("l3_single", 32'(rd_valid2), 0);
      check("l3_idle",   32'(busy2), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
